// File: rtl/gpia_port_ctl_if.sv
// Bus-side handshake bundle for the GPIA port controller: strobe/ack transaction
// signals with their write and read data, parameterised by port width W.
interface gpia_port_ctl_if #(
  parameter int unsigned W = 16
) ();
  logic         cyc_i;
  logic         stb_i;
  logic         we_i;
  logic [2:0]   adr_i;
  logic [W-1:0] dat_i;
  logic [W-1:0] dat_o;
  logic         ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/gpia_port_ctl.sv
// GPIA port controller: OUT/DDR/IEN registers behind a two-cycle strobe/ack bus,
// synchronised pad readback. Define GPIA_EDGE_IRQ_EN for rising-edge interrupt flags.
module gpia_port_ctl #(
  parameter int unsigned W = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  gpia_port_ctl_if.slave bus,
  input  logic [W-1:0]  inp_i,
  output logic [W-1:0]  out_o,
  output logic [W-1:0]  ddr_o,
  output logic          irq_o
);

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] A_DATA = AW'(0);
  localparam logic [AW-1:0] A_DDR  = AW'(1);
  localparam logic [AW-1:0] A_SET  = AW'(2);
  localparam logic [AW-1:0] A_CLR  = AW'(3);
  localparam logic [AW-1:0] A_RAW  = AW'(4);
  localparam logic [AW-1:0] A_EDGE = AW'(5);
  localparam logic [AW-1:0] A_IEN  = AW'(6);

  typedef enum logic {IDLE, ACK} state_e;

  state_e       state_q, state_d;
  logic         ack_q, ack_d;
  logic [W-1:0] dat_q, dat_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] ddr_q, ddr_d;
  logic [W-1:0] ien_q, ien_d;
  logic [W-1:0] sync1_q, sin_q;
  logic [W-1:0] rb;
  logic [W-1:0] rd_data;
  logic [W-1:0] edge_rd;

`ifdef GPIA_EDGE_IRQ_EN
  logic [W-1:0] sprev_q;
  logic [W-1:0] edge_q, edge_d;
  logic [W-1:0] edge_clr;
  logic [W-1:0] edge_set;
  logic         irq_q, irq_d;
`endif

  // Two-flop synchroniser on the asynchronous pad inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sin_q   <= '0;
    end else begin
      sync1_q <= inp_i;
      sin_q   <= sync1_q;
    end
  end

  assign rb = (ddr_q & out_q) | (~ddr_q & sin_q);

`ifdef GPIA_EDGE_IRQ_EN
  assign edge_rd = edge_q;
`else
  assign edge_rd = '0;
`endif

  // Read mux; reflects register state before the accepting edge
  always_comb begin
    rd_data = '0;
    case (bus.adr_i)
      A_DATA:  rd_data = rb;
      A_DDR:   rd_data = ddr_q;
      A_SET:   rd_data = out_q;
      A_CLR:   rd_data = out_q;
      A_RAW:   rd_data = sin_q;
      A_EDGE:  rd_data = edge_rd;
      A_IEN:   rd_data = ien_q;
      default: rd_data = '0;
    endcase
  end

  // Transaction FSM: accept in IDLE, acknowledge for one cycle in ACK
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    out_d   = out_q;
    ddr_d   = ddr_q;
    ien_d   = ien_q;
`ifdef GPIA_EDGE_IRQ_EN
    edge_clr = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = bus.we_i ? '0 : rd_data;
          if (bus.we_i) begin
            case (bus.adr_i)
              A_DATA: out_d = bus.dat_i;
              A_DDR:  ddr_d = bus.dat_i;
              A_SET:  out_d = out_q | bus.dat_i;
              A_CLR:  out_d = out_q & ~bus.dat_i;
              A_IEN:  ien_d = bus.dat_i;
`ifdef GPIA_EDGE_IRQ_EN
              A_EDGE: edge_clr = bus.dat_i;
`endif
              default: ;
            endcase
          end
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= '0;
      ddr_q   <= '0;
      ien_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      ddr_q   <= ddr_d;
      ien_q   <= ien_d;
    end
  end

`ifdef GPIA_EDGE_IRQ_EN
  // Set is OR-ed after the clear so a simultaneous new edge is not lost
  assign edge_set = ~ddr_q & sin_q & ~sprev_q;

  always_comb begin
    edge_d = (edge_q & ~edge_clr) | edge_set;
    irq_d  = |(edge_q & ien_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sprev_q <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sprev_q <= sin_q;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign out_o     = out_q;
  assign ddr_o     = ddr_q;
  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_gpia_port_ctl.sv
// Scoreboard bench for gpia_port_ctl at W=8: directed transactions push expected
// read data; a negedge monitor pops and compares on every acknowledge.
module tb_gpia_port_ctl;
  localparam int unsigned W = 8;

`ifdef GPIA_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic         chk;
    logic [W-1:0] dat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inp;
  logic [W-1:0] out_w;
  logic [W-1:0] ddr_w;
  logic         irq;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  gpia_port_ctl_if #(.W(W)) bus_if ();

  gpia_port_ctl #(.W(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if),
    .inp_i  (inp),
    .out_o  (out_w),
    .ddr_o  (ddr_w),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Issue one transaction from a negedge; returns at the negedge after ack drops
  task automatic xact(input logic we, input logic [2:0] adr, input logic [W-1:0] wd,
                      input logic chk, input logic [W-1:0] exp);
    exp_t e;
    e.chk = chk;
    e.dat = exp;
    sb_q.push_back(e);
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = we;
    bus_if.adr_i = adr;
    bus_if.dat_i = wd;
    @(posedge clk);
    #1;
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    @(negedge clk);
    check("ack_rise", 32'(bus_if.ack_o), 32'd1);
    @(negedge clk);
    check("ack_fall", 32'(bus_if.ack_o), 32'd0);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [W-1:0] d);
    xact(1'b1, adr, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [W-1:0] exp);
    xact(1'b0, adr, '0, 1'b1, exp);
  endtask

  // Monitor: every ack must match a queued expectation; dat_o is 0 otherwise
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_if.ack_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk) check("rdata", 32'(bus_if.dat_o), 32'(e.dat));
        end
      end else begin
        check("dat_idle", 32'(bus_if.dat_o), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n        = 1'b0;
    inp          = '0;
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    bus_if.adr_i = '0;
    bus_if.dat_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_out", 32'(out_w), 32'h00);
    check("rst_ddr", 32'(ddr_w), 32'h00);
    check("rst_ack", 32'(bus_if.ack_o), 32'd0);
    check("rst_dat", 32'(bus_if.dat_o), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);

    // Readback mix: output bits from OUT, input bits from pads
    wr(3'd1, 8'hF0);
    wr(3'd0, 8'hA5);
    inp = 8'h3C;
    repeat (3) @(negedge clk);
    rd(3'd0, 8'hAC);
    rd(3'd1, 8'hF0);

    // SET / CLR sequencing
    wr(3'd0, 8'h00);
    wr(3'd2, 8'h81);
    wr(3'd3, 8'h01);
    rd(3'd2, 8'h80);
    check("setclr_out", 32'(out_w), 32'h80);

    // Strobe held high: one ack every two cycles
    e.chk = 1'b1;
    e.dat = 8'h80;
    sb_q.push_back(e);
    sb_q.push_back(e);
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = 1'b0;
    bus_if.adr_i = 3'd2;
    check("hold_ack0", 32'(bus_if.ack_o), 32'd0);
    @(negedge clk);
    check("hold_ack1", 32'(bus_if.ack_o), 32'd1);
    @(negedge clk);
    check("hold_ack2", 32'(bus_if.ack_o), 32'd0);
    @(negedge clk);
    check("hold_ack3", 32'(bus_if.ack_o), 32'd1);
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    @(negedge clk);
    check("hold_end", 32'(bus_if.ack_o), 32'd0);

    // Strobe without cyc is ignored
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = 1'b1;
    bus_if.adr_i = 3'd0;
    bus_if.dat_i = 8'hFF;
    repeat (2) @(negedge clk);
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    check("nocyc_ack", 32'(bus_if.ack_o), 32'd0);
    check("nocyc_out", 32'(out_w), 32'h80);

    // Synchroniser latency
    inp = 8'h00;
    repeat (4) @(negedge clk);
    inp = 8'hFF;
    @(negedge clk);
    rd(3'd4, 8'h00);
    inp = 8'h00;
    repeat (4) @(negedge clk);
    inp = 8'hFF;
    repeat (3) @(negedge clk);
    rd(3'd4, 8'hFF);

    // Reset asserted in the strobe cycle aborts the write
    inp          = 8'h00;
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = 1'b1;
    bus_if.adr_i = 3'd0;
    bus_if.dat_i = 8'h55;
    rst_n        = 1'b0;
    @(negedge clk);
    check("rstmid_ack", 32'(bus_if.ack_o), 32'd0);
    check("rstmid_out", 32'(out_w), 32'h00);
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    rst_n        = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_out2", 32'(out_w), 32'h00);
    check("rstmid_ddr", 32'(ddr_w), 32'h00);
    check("rstmid_ack2", 32'(bus_if.ack_o), 32'd0);

    // Edge interrupt on an input bit
    wr(3'd6, 8'h02);
    inp = 8'h02;
    repeat (4) @(negedge clk);
    check("edge_irq_set", 32'(irq), 32'(EDGE_EN));
    rd(3'd5, EDGE_EN ? 8'h02 : 8'h00);
    wr(3'd5, 8'h02);
    check("edge_irq_clr", 32'(irq), 32'd0);
    rd(3'd5, 8'h00);
    rd(3'd6, 8'h02);

    // Output-configured bit never flags an edge
    wr(3'd1, 8'h02);
    inp = 8'h00;
    repeat (4) @(negedge clk);
    inp = 8'h02;
    repeat (5) @(negedge clk);
    rd(3'd5, 8'h00);
    check("edge_out_irq", 32'(irq), 32'd0);
    rd(3'd0, 8'h00);
    rd(3'd4, 8'h02);

    // Reserved address reads 0 and ignores writes
    wr(3'd7, 8'hFF);
    rd(3'd7, 8'h00);
    rd(3'd1, 8'h02);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpia_port_ctl.md
Name: gpia_port_ctl

Overview:
- Bus-side controller for one GPIA port of W bits.
- Sequences single-cycle-strobe bus transactions into the port's OUT and DDR registers.
- Synchronises pad inputs and returns the per-bit readback: OUT value for output bits, pad value for input bits.
- Sits between a processing element's I/O bus and the pad ring. Flags rising edges on input bits for interrupts.

Parameters:
- W, 16, port width in bits (1..32).

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cyc_i  in  1  bus cycle valid
- stb_i  in  1  transaction strobe
- we_i  in  1  1=write, 0=read
- adr_i  in  3  register select
- dat_i  in  W  write data
- dat_o  out  W  read data, valid while ack_o=1, else 0
- ack_o  out  1  transaction acknowledge
- inp_i  in  W  raw pad inputs (asynchronous)
- out_o  out  W  OUT register to pad drivers
- ddr_o  out  W  direction register, 1=output
- irq_o  out  1  interrupt request

Behaviour:
- Reset (rst_ni low, asynchronous): out_o=0, ddr_o=0, ack_o=0, dat_o=0, sync flops=0, EDGE=0, IEN=0, irq_o=0, FSM=IDLE. Reset asserted mid-transaction aborts it: no ack is issued and no write commits.
- Input sync: two-flop synchroniser on inp_i gives sin. A pad change is visible in sin 2 clocks later.
- Readback: rb = (ddr_o & out_o) | (~ddr_o & sin).
- FSM, two states:
  - IDLE: ack_o=0. If cyc_i&stb_i, then at that edge commit any write, register dat_o, and go to ACK.
  - ACK: ack_o=1 for exactly one cycle, dat_o holds read data. Next edge returns to IDLE unconditionally, and dat_o becomes 0.
  - A strobe held high is re-accepted in the following IDLE cycle, giving at most one ack every 2 cycles.
  - Latency: ack_o is asserted in the cycle after the strobe is sampled.
  - A strobe without cyc_i is ignored.
- Register map, write side effects commit at the IDLE->ACK edge:
  - 0 DATA: write sets out_o=dat_i; read returns rb.
  - 1 DDR: write sets ddr_o=dat_i; read returns ddr_o.
  - 2 SET: write does out_o |= dat_i; read returns out_o.
  - 3 CLR: write does out_o &= ~dat_i; read returns out_o.
  - 4 RAW: read returns sin; write ignored.
  - 5 EDGE: see Optional Feature.
  - 6 IEN: read/write W-bit interrupt enable.
  - 7 reserved: reads 0, writes ignored.
- Reading DATA in the same transaction as a DDR write is impossible, since each transaction has one address. A read of DATA reflects register state before that transaction's edge.
- Bits above W on the bus do not exist. dat_i is exactly W bits.

Optional Feature:
- Macro: GPIA_EDGE_IRQ_EN.
- Defined:
  - sprev = sin delayed one clock, reset 0.
  - EDGE[b] sets when ~ddr_o[b] & sin[b] & ~sprev[b].
  - EDGE read returns pending flags. Writing 1 to a bit clears it.
  - If set and clear hit the same bit in the same cycle, set wins.
  - irq_o is registered: irq_o = |(EDGE & IEN), updated one clock after EDGE changes.
  - Output-configured bits never set EDGE. Changing DDR does not clear pending flags.
- Not defined:
  - No EDGE or sprev storage. EDGE reads 0 and writes are ignored.
  - irq_o is tied 0. IEN is still readable and writable.

Test Plan (W=8):
- Reset and idle: hold rst_ni=0, then release with no strobe for 5 clocks -> out_o=00, ddr_o=00, ack_o=0, dat_o=00, irq_o=0.
- DATA readback mix: write DDR=F0, write DATA=A5, drive inp_i=3C, wait 3 clocks, read DATA -> ack_o high exactly one cycle after the strobe, dat_o=AC.
- SET/CLR sequencing: DATA=00, SET 81, CLR 01, read SET -> out_o=80, dat_o=80. stb_i held high across 4 cycles -> ack_o pattern 0,1,0,1.
- Sync latency: inp_i toggles 00->FF at cycle n -> RAW read issued at n+1 returns 00; issued at n+3 returns FF.
- Reset mid-transaction: strobe a write of DATA=55, assert rst_ni in the same cycle -> no ack, out_o=00.
- Edge IRQ (macro defined): DDR=00, IEN=02, inp_i bit1 rises -> EDGE=02 and irq_o=1 within 4 clocks. Write EDGE=02 -> irq_o=0 one clock after the ack. Bit1 with DDR=02 rising -> no flag.
